// File: rtl/bubble_scheduler.sv
// bubble_scheduler: picks the overlay sprite per frame (items preempt round-robin status bubbles); ports clk, reset, frame_tick, status_req[5:0], item_req[4:0], plot_done -> draw_req, draw_sel[3:0], frame_overrun, current_state[1:0]
module bubble_scheduler #(
  parameter int DWELL_FRAMES = 60,
  parameter int ITEM_FRAMES  = 30,
  parameter int CW           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [5:0] status_req,
  input  logic [4:0] item_req,
  input  logic       plot_done,
  output logic       draw_req,
  output logic [3:0] draw_sel,
  output logic       frame_overrun,
  output logic [1:0] current_state
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WAIT_TICK} state_t;
  state_t        state_q, state_d;
  logic [3:0]    draw_sel_q, draw_sel_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [4:0]    item_pend_q, item_pend_d, item_clr;
  logic          draw_req_q, draw_req_d, frame_overrun_q, frame_overrun_d;
  logic [5:0]    st_rot;
  logic [2:0]    st_off, st_idx, it_idx;
  logic [3:0]    st_sum;
  logic          keep, sel_now, have_item, have_st;
  always_comb begin
    it_idx = '0;
    st_off = '0;
    st_rot = 6'({status_req, status_req} >> rr_ptr_q);
    for (int i = 4; i >= 0; i--) it_idx = item_pend_q[i] ? 3'(i) : it_idx;
    for (int i = 5; i >= 0; i--) st_off = st_rot[i] ? 3'(i) : st_off;
    st_sum = {1'b0, rr_ptr_q} + {1'b0, st_off};
    st_idx = st_sum >= 4'd6 ? 3'(st_sum - 4'd6) : st_sum[2:0];
    have_item = item_pend_q != '0;
    have_st = status_req != '0;
    keep = dwell_q != '0 && (draw_sel_q > 4'd6 || (status_req[3'(draw_sel_q - 4'd1)] && !have_item));
    sel_now = frame_tick && (state_q == IDLE || (state_q == WAIT_TICK && !keep));
    item_clr = sel_now && have_item ? 5'b1 << it_idx : '0;
    item_pend_d = (item_pend_q & ~item_clr) | item_req;
    rr_ptr_d = sel_now && !have_item && have_st ? (st_idx == 3'd5 ? 3'd0 : st_idx + 3'd1) : rr_ptr_q;
    draw_sel_d = !sel_now ? draw_sel_q : have_item ? 4'd7 + {1'b0, it_idx} : have_st ? 4'd1 + {1'b0, st_idx} : 4'd0;
    dwell_d = sel_now ? (have_item ? CW'(ITEM_FRAMES - 1) : CW'(DWELL_FRAMES - 1))
            : state_q == WAIT_TICK && frame_tick ? dwell_q - CW'(1) : dwell_q;
    state_d = sel_now ? (draw_sel_d != '0 ? ISSUE : IDLE)
            : state_q == ISSUE ? BUSY
            : state_q == BUSY && plot_done ? WAIT_TICK
            : state_q == WAIT_TICK && frame_tick ? ISSUE : state_q;
    draw_req_d = state_d == ISSUE;
    frame_overrun_d = frame_tick && (state_q == ISSUE || state_q == BUSY);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      draw_sel_q      <= '0;
      dwell_q         <= '0;
      rr_ptr_q        <= '0;
      item_pend_q     <= '0;
      draw_req_q      <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      draw_sel_q      <= draw_sel_d;
      dwell_q         <= dwell_d;
      rr_ptr_q        <= rr_ptr_d;
      item_pend_q     <= item_pend_d;
      draw_req_q      <= draw_req_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end
  assign draw_req      = draw_req_q;
  assign draw_sel      = draw_sel_q;
  assign frame_overrun = frame_overrun_q;
  assign current_state = state_q;
endmodule

// File: tb/tb_bubble_scheduler.sv
// tb_bubble_scheduler: directed scenarios plus randomized run against a frame-level reference model
module tb_bubble_scheduler;
  localparam int DF = 3;
  localparam int IF = 2;
  logic       clk = 0;
  logic       reset = 1;
  logic       frame_tick = 0;
  logic [5:0] status_req = '0;
  logic [4:0] item_req = '0;
  logic       plot_done = 0;
  logic       draw_req, frame_overrun;
  logic [3:0] draw_sel;
  logic [1:0] current_state;
  int n_chk = 0;
  int n_fail = 0;
  bubble_scheduler #(.DWELL_FRAMES(DF), .ITEM_FRAMES(IF), .CW(4)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .status_req(status_req),
    .item_req(item_req), .plot_done(plot_done), .draw_req(draw_req), .draw_sel(draw_sel),
    .frame_overrun(frame_overrun), .current_state(current_state)
  );
  always #5 clk = ~clk;
  typedef struct {
    int       phase;
    int       sel;
    int       left;
    int       rr;
    bit [4:0] pend;
    bit       req;
    bit       ovr;
  } ms_t;
  ms_t m;
  function automatic ms_t nxt(ms_t s, bit tick, bit [5:0] st, bit [4:0] it, bit done);
    ms_t n = s;
    bit do_sel = 0;
    bit found = 0;
    bit [4:0] clr = '0;
    int b;
    n.ovr = tick && (s.phase == 1 || s.phase == 2);
    case (s.phase)
      0: do_sel = tick;
      1: n.phase = 2;
      2: if (done) n.phase = 3;
      default: if (tick) begin
        if (s.left == 0 || (s.sel <= 6 && (!st[s.sel-1] || s.pend != 0))) do_sel = 1;
        else begin
          n.left = s.left - 1;
          n.phase = 1;
        end
      end
    endcase
    if (do_sel) begin
      n.sel = 0;
      for (int i = 0; i < 5; i++)
        if (!found && s.pend[i]) begin
          found = 1; n.sel = 7 + i; n.left = IF - 1; clr[i] = 1;
        end
      for (int k = 0; k < 6; k++) begin
        b = (s.rr + k) % 6;
        if (!found && st[b]) begin
          found = 1; n.sel = 1 + b; n.rr = (b + 1) % 6; n.left = DF - 1;
        end
      end
      n.phase = found ? 1 : 0;
    end
    n.pend = (s.pend & ~clr) | it;
    n.req = n.phase == 1;
    return n;
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) m <= '{0, 0, 0, 0, 5'b0, 1'b0, 1'b0};
    else m <= nxt(m, frame_tick, status_req, item_req, plot_done);
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1; frame_tick = 0; item_req = '0; plot_done = 0; status_req = '0;
    cycle(); cycle();
    reset = 0;
    cycle();
  endtask
  task automatic frame(output logic [3:0] sel, output logic req, output logic [1:0] st);
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    sel = draw_sel; req = draw_req; st = current_state;
    repeat (5) cycle();
    plot_done = 1;
    cycle();
    plot_done = 0;
    cycle();
  endtask
  task automatic test_reset();
    reset = 1;
    cycle();
    n_chk++;
    if (current_state !== 2'd0 || draw_sel !== 4'd0 || draw_req !== 1'b0 || frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d sel=%0d req=%b ovr=%b, required 0 0 0 0", current_state, draw_sel, draw_req, frame_overrun);
    end
    reset = 0;
    cycle();
  endtask
  task automatic test_single_bubble();
    logic [3:0] s; logic r; logic [1:0] st;
    do_reset();
    status_req = 6'b000001;
    for (int t = 0; t < 4; t++) begin
      frame(s, r, st);
      n_chk++;
      if (s !== 4'd1 || r !== 1'b1 || st !== 2'd1) begin
        n_fail++;
        $display("FAIL single_bubble T%0d: sel=%0d req=%b state=%0d, required sel=1 req=1 state=1", t + 1, s, r, st);
      end
    end
  endtask
  task automatic test_rotation();
    logic [3:0] s; logic r; logic [1:0] st;
    int exp_sel[10] = '{1, 1, 1, 3, 3, 3, 6, 6, 6, 1};
    do_reset();
    status_req = 6'b100101;
    for (int t = 0; t < 10; t++) begin
      frame(s, r, st);
      n_chk++;
      if (s !== 4'(exp_sel[t]) || r !== 1'b1) begin
        n_fail++;
        $display("FAIL rotation T%0d: sel=%0d req=%b, required sel=%0d req=1", t + 1, s, r, exp_sel[t]);
      end
    end
  endtask
  task automatic test_item_preempt();
    logic [3:0] s; logic r; logic [1:0] st;
    int exp_sel[4] = '{1, 7, 7, 2};
    do_reset();
    status_req = 6'b000011;
    for (int t = 0; t < 4; t++) begin
      if (t == 1) begin
        item_req = 5'b00001;
        cycle();
        item_req = '0;
      end
      frame(s, r, st);
      n_chk++;
      if (s !== 4'(exp_sel[t]) || r !== 1'b1) begin
        n_fail++;
        $display("FAIL item_preempt T%0d: sel=%0d req=%b, required sel=%0d req=1", t + 1, s, r, exp_sel[t]);
      end
    end
  endtask
  task automatic test_two_items();
    logic [3:0] s; logic r; logic [1:0] st;
    int exp_sel[5] = '{7, 7, 11, 11, 0};
    do_reset();
    item_req = 5'b10001;
    cycle();
    item_req = '0;
    for (int t = 0; t < 5; t++) begin
      frame(s, r, st);
      n_chk++;
      if (s !== 4'(exp_sel[t]) || r !== (exp_sel[t] != 0) || st !== (exp_sel[t] != 0 ? 2'd1 : 2'd0)) begin
        n_fail++;
        $display("FAIL two_items T%0d: sel=%0d req=%b state=%0d, required sel=%0d", t + 1, s, r, st, exp_sel[t]);
      end
      if (t == 2) begin
        n_chk++;
        if (dut.item_pend_q !== 5'b0) begin
          n_fail++;
          $display("FAIL two_items pend: item_pend=%b, required 00000", dut.item_pend_q);
        end
      end
    end
  endtask
  task automatic test_overrun();
    logic [3:0] s; logic r; logic [1:0] st;
    do_reset();
    status_req = 6'b000011;
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    cycle();
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    n_chk++;
    if (frame_overrun !== 1'b1 || current_state !== 2'd2 || draw_sel !== 4'd1) begin
      n_fail++;
      $display("FAIL overrun: ovr=%b state=%0d sel=%0d, required 1 2 1", frame_overrun, current_state, draw_sel);
    end
    cycle();
    n_chk++;
    if (frame_overrun !== 1'b0 || current_state !== 2'd2) begin
      n_fail++;
      $display("FAIL overrun_pulse: ovr=%b state=%0d, required 0 2", frame_overrun, current_state);
    end
    plot_done = 1;
    cycle();
    plot_done = 0;
    status_req = 6'b000010;
    frame(s, r, st);
    n_chk++;
    if (s !== 4'd2 || r !== 1'b1) begin
      n_fail++;
      $display("FAIL status_drop: sel=%0d req=%b, required 2 1", s, r);
    end
    status_req = '0;
    frame(s, r, st);
    n_chk++;
    if (s !== 4'd0 || r !== 1'b0 || st !== 2'd0) begin
      n_fail++;
      $display("FAIL status_drop_idle: sel=%0d req=%b state=%0d, required 0 0 0", s, r, st);
    end
  endtask
  task automatic test_reset_mid_draw();
    logic [3:0] s; logic r; logic [1:0] st;
    do_reset();
    status_req = 6'b000001;
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    cycle();
    item_req = 5'b00100;
    cycle();
    item_req = '0;
    reset = 1;
    #1;
    n_chk++;
    if (current_state !== 2'd0 || draw_req !== 1'b0 || draw_sel !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid: state=%0d req=%b sel=%0d, required 0 0 0", current_state, draw_req, draw_sel);
    end
    cycle();
    reset = 0;
    status_req = '0;
    cycle();
    frame(s, r, st);
    n_chk++;
    if (s !== 4'd0 || r !== 1'b0 || st !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_tick: sel=%0d req=%b state=%0d, required 0 0 0", s, r, st);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      frame_tick = $urandom_range(0, 5) == 0;
      plot_done = $urandom_range(0, 2) == 0;
      item_req = $urandom_range(0, 19) == 0 ? 5'($urandom) : 5'b0;
      if ($urandom_range(0, 15) == 0) status_req = 6'($urandom);
      reset = $urandom_range(0, 499) == 0;
      cycle();
      n_chk++;
      if (draw_sel !== 4'(m.sel) || draw_req !== m.req || frame_overrun !== m.ovr || current_state !== 2'(m.phase)) begin
        n_fail++;
        $display("FAIL random c%0d: sel=%0d req=%b ovr=%b state=%0d, required sel=%0d req=%b ovr=%b state=%0d",
                 c, draw_sel, draw_req, frame_overrun, current_state, m.sel, m.req, m.ovr, m.phase);
      end
    end
    reset = 0;
  endtask
  initial begin
    test_reset();
    test_single_bubble();
    test_rotation();
    test_item_preempt();
    test_two_items();
    test_overrun();
    test_reset_mid_draw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
